uart_tx_serializer: RTL and testbench

UART transmitter that serializes one byte per handshake onto the TX line: start bit, DATA_BITS data bits LSB first, optional parity bit, stop bit(s). It sits directly downstream of the FIFO-to-UART word buffer, consuming its `start`/`data` pair and returning a one-cycle `done` pulse per byte. It contains its own oversampling baud-tick generator, resynchronised at every frame start so bit periods are exact.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 30 +++
 rtl/uart_tx_serializer.sv | 143 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding and baud divisor arithmetic.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   localparam int OVERSAMPLE_DEF = 16;

   // Clock cycles per oversampling tick, truncated toward zero.
   function automatic int baud_divisor(input int clk_freq, input int baud_rate,
                                       input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divide-by-DIVISOR tick source; clear restarts the count so the
// first tick after a clear lands exactly DIVISOR cycles later.
module baud_tick_gen #(
   parameter int DIVISOR = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   logic [CW-1:0] cnt_q;
   logic          term;

   assign term = (cnt_q == CW'(DIVISOR - 1));
   assign tick = term;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear || term) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity, stop bit(s).
// One byte per start/done handshake; all outputs registered.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 19_200,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_uart_start,
   input  logic [DATA_BITS-1:0] i_uart_data,
   output logic                 o_uart_done,
   output logic                 o_busy,
   output logic                 o_tx
);

   localparam int DIVISOR = baud_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int OSW     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BCW     = $clog2(DATA_BITS + STOP_BITS + 1);

   if (DIVISOR < 1) begin : g_bad_divisor
      $error("uart_tx_serializer: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
   end

   uart_state_e          state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 parity_q;
   logic [OSW-1:0]       os_cnt_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 done_q;

   logic tick;
   logic accept;
   logic bit_end;

   // busy_q is still high in the done cycle, which keeps a start there from being taken.
   assign accept  = (state_q == ST_IDLE) && !busy_q && i_uart_start;
   assign bit_end = tick && (os_cnt_q == OSW'(OVERSAMPLE - 1));
   assign shift_d = shift_q >> 1;

   baud_tick_gen #(
      .DIVISOR(DIVISOR)
   ) u_tick (
      .clk    (i_clk),
      .reset_n(i_reset_n),
      .clear  (accept),
      .tick   (tick)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (tick && (state_q != ST_IDLE)) begin
            os_cnt_q <= bit_end ? '0 : os_cnt_q + OSW'(1);
         end
         case (state_q)
            ST_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (accept) begin
                  shift_q   <= i_uart_data;
                  parity_q  <= (^i_uart_data) ^ (PARITY_ODD != 0);
                  os_cnt_q  <= '0;
                  bit_cnt_q <= '0;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx_q      <= shift_q[0];
                  bit_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     if (PARITY_EN != 0) begin
                        tx_q    <= parity_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                     shift_q   <= shift_d;
                     tx_q      <= shift_d[0];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tx_q    <= 1'b1;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     done_q    <= 1'b1;
                     state_q   <= ST_IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_tx        = tx_q;
   assign o_busy      = busy_q;
   assign o_uart_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (plain, even parity, odd parity,
// two stop bits) driven by directed frames and checked by per-instance monitors.
module tb_uart_tx_serializer;

   localparam int BIT_CYC = 160;

   typedef struct {
      logic [11:0] pat;
      int          nbits;
      bit          abort;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] start_r = '0;
   logic [7:0] data_r = '0;
   logic [3:0] tx_w, busy_w, done_w;

   int cyc = 0;
   int checks = 0;
   int fails = 0;
   int accept_cyc [4];
   int done_cyc [4];
   frame_t exp_q [4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(1), .OVERSAMPLE(16),
      .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_plain (
      .i_clk(clk), .i_reset_n(rst_n), .i_uart_start(start_r[0]), .i_uart_data(data_r),
      .o_uart_done(done_w[0]), .o_busy(busy_w[0]), .o_tx(tx_w[0]));

   uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(1), .OVERSAMPLE(16),
      .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .i_clk(clk), .i_reset_n(rst_n), .i_uart_start(start_r[1]), .i_uart_data(data_r),
      .o_uart_done(done_w[1]), .o_busy(busy_w[1]), .o_tx(tx_w[1]));

   uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(1), .OVERSAMPLE(16),
      .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .i_clk(clk), .i_reset_n(rst_n), .i_uart_start(start_r[2]), .i_uart_data(data_r),
      .o_uart_done(done_w[2]), .o_busy(busy_w[2]), .o_tx(tx_w[2]));

   uart_tx_serializer #(.CLK_FREQ(160), .BAUD_RATE(1), .OVERSAMPLE(16),
      .DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_stop2 (
      .i_clk(clk), .i_reset_n(rst_n), .i_uart_start(start_r[3]), .i_uart_data(data_r),
      .o_uart_done(done_w[3]), .o_busy(busy_w[3]), .o_tx(tx_w[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Pattern is written in line order, leftmost bit transmitted first.
   task automatic send(input int id, input logic [7:0] d, input logic [11:0] pat,
                       input int nbits, input bit abort);
      frame_t f;
      f.pat = pat;
      f.nbits = nbits;
      f.abort = abort;
      exp_q[id].push_back(f);
      data_r = d;
      start_r[id] = 1'b1;
      @(posedge clk);
      #1 start_r[id] = 1'b0;
   endtask

   task automatic wait_done(input int id);
      bit seen = 0;
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk);
         #1;
         if (done_w[id] === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk($sformatf("d%0d_done_within_bound", id), {31'd0, seen}, 32'd1);
   endtask

   task automatic monitor(input int id);
      frame_t f;
      int     k, nf, b, off;
      bit     early_done, busy_drop, aborted;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) continue;
         if (done_w[id] !== 1'b0) chk($sformatf("d%0d_idle_done", id), {31'd0, done_w[id]}, 32'd0);
         if (busy_w[id] !== 1'b1) continue;
         k = cyc;
         accept_cyc[id] = k;
         chk($sformatf("d%0d_frame_expected", id), {31'd0, exp_q[id].size() != 0}, 32'd1);
         if (exp_q[id].size() == 0) begin
            while (busy_w[id] === 1'b1 && rst_n === 1'b1) @(negedge clk);
            continue;
         end
         f = exp_q[id].pop_front();
         nf = f.nbits * BIT_CYC;
         early_done = 0;
         busy_drop = 0;
         aborted = 0;
         for (int j = 0; j <= nf + 1; j++) begin
            if (j > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
               aborted = 1;
               break;
            end
            if (j < nf) begin
               b = j / BIT_CYC;
               off = j % BIT_CYC;
               if (off == 0 || off == BIT_CYC / 2 || off == BIT_CYC - 1)
                  chk($sformatf("d%0d_bit%0d_off%0d", id, b, off), {31'd0, tx_w[id]},
                      {31'd0, f.pat[f.nbits - 1 - b]});
               if (done_w[id] !== 1'b0) early_done = 1;
               if (busy_w[id] !== 1'b1) busy_drop = 1;
            end else if (j == nf) begin
               done_cyc[id] = cyc;
               chk($sformatf("d%0d_done_at_F", id), {31'd0, done_w[id]}, 32'd1);
               chk($sformatf("d%0d_tx_idle_at_F", id), {31'd0, tx_w[id]}, 32'd1);
               chk($sformatf("d%0d_busy_at_F", id), {31'd0, busy_w[id]}, 32'd1);
               chk($sformatf("d%0d_no_early_done", id), {31'd0, early_done}, 32'd0);
               chk($sformatf("d%0d_busy_held", id), {31'd0, busy_drop}, 32'd0);
            end else begin
               chk($sformatf("d%0d_done_one_cycle", id), {31'd0, done_w[id]}, 32'd0);
               chk($sformatf("d%0d_busy_low_after", id), {31'd0, busy_w[id]}, 32'd0);
               chk($sformatf("d%0d_tx_idle_after", id), {31'd0, tx_w[id]}, 32'd1);
            end
         end
         chk($sformatf("d%0d_abort_status", id), {31'd0, aborted}, {31'd0, f.abort});
         while (rst_n !== 1'b1) @(negedge clk);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_mon
      initial monitor(g);
   end

   initial begin
      // Reset held with start asserted: nothing may start.
      start_r[0] = 1'b1;
      data_r = 8'h55;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("rst_tx", {31'd0, tx_w[0]}, 32'd1);
         chk("rst_busy", {31'd0, busy_w[0]}, 32'd0);
         chk("rst_done", {31'd0, done_w[0]}, 32'd0);
      end
      start_r[0] = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("idle_tx_after_rst", {31'd0, tx_w[0]}, 32'd1);

      // 0x55, no parity.
      send(0, 8'h55, 12'b0101010101, 10, 0);
      wait_done(0);
      repeat (3) @(posedge clk);
      #1;

      // 0x55 then 0xA3, start raised the cycle after done is seen.
      send(0, 8'h55, 12'b0101010101, 10, 0);
      wait_done(0);
      @(posedge clk);
      #1 send(0, 8'hA3, 12'b0110001011, 10, 0);
      @(negedge clk);
      #1 chk("b2b_accept_after_done", accept_cyc[0] - done_cyc[0], 32'd2);
      wait_done(0);
      repeat (3) @(posedge clk);
      #1;

      // 0x3C, then data changed and start held mid-frame and through done.
      send(0, 8'h3C, 12'b0001111001, 10, 0);
      repeat (500) @(posedge clk);
      #1;
      data_r = 8'hFF;
      start_r[0] = 1'b1;
      wait_done(0);
      @(posedge clk);
      #1 start_r[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("no_start_in_done_cycle", {31'd0, busy_w[0]}, 32'd0);

      // 0x07 with even and odd parity, 0x55 with two stop bits.
      send(1, 8'h07, 12'b01110000011, 11, 0);
      send(2, 8'h07, 12'b01110000001, 11, 0);
      send(3, 8'h55, 12'b01010101011, 11, 0);
      repeat (1800) @(posedge clk);
      #1;

      // 0x00 aborted by reset during data bit 3, then a clean 0x81 frame.
      send(0, 8'h00, 12'b0000000001, 10, 1);
      repeat (699) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", {31'd0, tx_w[0]}, 32'd1);
      chk("async_rst_busy", {31'd0, busy_w[0]}, 32'd0);
      chk("async_rst_done", {31'd0, done_w[0]}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 send(0, 8'h81, 12'b0100000011, 10, 0);
      wait_done(0);
      repeat (5) @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++)
         chk($sformatf("d%0d_queue_drained", i), exp_q[i].size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
